dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between three requesters: CPU load/store, PS/2 key-code writes and VGA framebuffer reads.
- CPU has absolute priority.
- Key codes are buffered in a small FIFO and written to a mailbox word whenever the port is free.
- VGA reads are granted by req/gnt handshake, round-robin against keyboard drains; sits between CPU/Ps2_Key/VGA controller and the memory array.

---
 rtl/dmem_port_arbiter_pkg.sv | 25 ++
 rtl/dmem_port_arbiter_if.sv | 37 +++
 rtl/dmem_port_arbiter_kb_code_fifo.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 97 +++++++++
 tb/tb_dmem_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
//   owner_t   : which requester drives the memory port this cycle
//   KB_NEW_BIT: "new key" flag position in the key mailbox word
//   kb_word() : builds the mailbox word written for a key code
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_KB,
        OWN_VGA
    } owner_t;

    localparam int KB_NEW_BIT = 8;

    // Software clears the new-key flag after reading the code.
    function automatic logic [31:0] kb_word(input logic [7:0] code);
        logic [31:0] w;
        w             = '0;
        w[7:0]        = code;
        w[KB_NEW_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, keyboard, VGA and memory-side signals around the
// data-memory port arbiter.
//   slave  : arbiter view (requests in, memory bus and responses out)
//   master : environment view (CPU, PS/2, VGA controller and memory array)
interface dmem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        kb_valid;
    logic [7:0]  kb_code;
    logic        kb_overflow;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd, kb_valid, kb_code,
               vga_req, vga_addr, mem_rd,
        output cpu_rd, kb_overflow, vga_gnt, vga_rvalid, vga_rdata,
               mem_we, mem_addr, mem_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd, kb_valid, kb_code,
               vga_req, vga_addr, mem_rd,
        input  cpu_rd, kb_overflow, vga_gnt, vga_rvalid, vga_rdata,
               mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/dmem_port_arbiter_kb_code_fifo.sv
// Small FIFO of 8-bit PS/2 key codes.
//   clk, rst : clock, async active-low reset (flushes the FIFO)
//   push/din : enqueue a code
//   pop      : dequeue head (ignored when empty)
//   dout     : head entry, valid while !empty
//   full/empty status, drop = push refused this cycle
module kb_code_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       drop
);
    localparam int AW = $clog2(DEPTH);

    // Extra wrap bit separates full from empty when the indices match.
    logic [AW:0]   wptr, rptr;
    logic [7:0]    mem [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU has absolute priority; otherwise buffered
// key codes and VGA reads share the port round-robin.
//   clk, rst : clock, async active-low reset
//   bus      : CPU, keyboard, VGA and memory signals (slave modport)
// Key codes land in a mailbox word at KB_ADDR. VGA read data comes back one
// cycle after vga_gnt with vga_rvalid, and is held until the next read.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] KB_ADDR    = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);
    owner_t      owner;
    logic        last_kb;     // 1: keyboard got the last shared grant
    logic        kb_empty, kb_full, kb_drop, kb_pop;
    logic [7:0]  kb_head;
    logic        kb_want, vga_want;
    logic        overflow;
    logic        rvalid;
    logic [31:0] rdata_q;

    kb_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.kb_valid),
        .pop   (kb_pop),
        .din   (bus.kb_code),
        .dout  (kb_head),
        .full  (kb_full),
        .empty (kb_empty),
        .drop  (kb_drop)
    );

    // Keyboard and VGA are masked while reset is held so the port idles.
    assign kb_want  = !kb_empty && rst;
    assign vga_want = bus.vga_req && rst;

    always_comb begin
        owner = OWN_NONE;
        if (bus.cpu_req)             owner = OWN_CPU;
        else if (kb_want && vga_want) owner = last_kb ? OWN_VGA : OWN_KB;
        else if (kb_want)            owner = OWN_KB;
        else if (vga_want)           owner = OWN_VGA;
    end

    assign kb_pop = (owner == OWN_KB);

    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        bus.vga_gnt  = 1'b0;
        case (owner)
            OWN_CPU: begin
                bus.mem_we   = bus.cpu_we;
                bus.mem_addr = bus.cpu_addr;
                bus.mem_wd   = bus.cpu_wd;
            end
            OWN_KB: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = KB_ADDR;
                bus.mem_wd   = kb_word(kb_head);
            end
            OWN_VGA: begin
                bus.mem_addr = bus.vga_addr;
                bus.vga_gnt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_kb  <= 1'b0;   // as if VGA was last, so keyboard wins first tie
            overflow <= 1'b0;
            rvalid   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (owner == OWN_KB)  last_kb <= 1'b1;
            if (owner == OWN_VGA) last_kb <= 1'b0;
            if (kb_drop)          overflow <= 1'b1;
            rvalid <= (owner == OWN_VGA);
            if (rvalid)           rdata_q <= bus.mem_rd;
        end
    end

    // Memory read is synchronous, so the data for a grant is on mem_rd
    // exactly while rvalid is high; rdata_q keeps it afterwards.
    assign bus.vga_rvalid  = rvalid;
    assign bus.vga_rdata   = rvalid ? bus.mem_rd : rdata_q;
    assign bus.cpu_rd      = bus.mem_rd;
    assign bus.kb_overflow = overflow;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.FIFO_DEPTH(4), .KB_ADDR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array model: synchronous read-old-data, word addressed.
    logic [31:0] mem_m [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem_m[bus.mem_addr[9:2]] <= bus.mem_wd;
        bus.mem_rd <= mem_m[bus.mem_addr[9:2]];
    end

    logic [31:0] kb_q[$];
    logic [31:0] vga_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: mailbox writes and VGA read returns.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.vga_gnt) vga_q.push_back(mem_m[bus.vga_addr[9:2]]);
            if (bus.vga_rvalid) begin
                chk("vga_rvalid_expected", 32'(vga_q.size() > 0), 32'd1);
                if (vga_q.size() > 0) chk("vga_rdata", bus.vga_rdata, vga_q.pop_front());
            end
            if (bus.mem_we && !bus.cpu_req) begin
                chk("kb_write_expected", 32'(kb_q.size() > 0), 32'd1);
                chk("kb_addr", bus.mem_addr, 32'h0);
                if (kb_q.size() > 0) chk("kb_wd", bus.mem_wd, kb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wd;
        logic        vga_req;
        logic [31:0] vga_addr;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_gnt;
        logic        rd_chk;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{0, 0, 32'h0,   32'h0,         0, 32'h0,   0, 32'h0,   32'h0,         0, 0, 32'h0};
        tbl[1] = '{1, 1, 32'h40,  32'hDEAD_BEEF, 0, 32'h0,   1, 32'h40,  32'hDEAD_BEEF, 0, 1, 32'h0000_011C};
        tbl[2] = '{1, 0, 32'h100, 32'h55,        0, 32'h0,   0, 32'h100, 32'h55,        0, 0, 32'h0};
        tbl[3] = '{1, 0, 32'h40,  32'h0,         1, 32'h100, 0, 32'h40,  32'h0,         0, 1, 32'h1234_5678};
        tbl[4] = '{0, 0, 32'h0,   32'h0,         1, 32'h100, 0, 32'h100, 32'h0,         1, 1, 32'hDEAD_BEEF};
        tbl[5] = '{0, 0, 32'h0,   32'h0,         1, 32'h40,  0, 32'h40,  32'h0,         1, 1, 32'h1234_5678};
        tbl[6] = '{0, 0, 32'h0,   32'h0,         0, 32'h0,   0, 32'h0,   32'h0,         0, 1, 32'hDEAD_BEEF};

        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        mem_m[8'h40] = 32'h1234_5678;   // byte address 0x100

        rst = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wd = 0;
        bus.kb_valid = 0; bus.kb_code = 0; bus.vga_req = 0; bus.vga_addr = 0;
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_vga_gnt", 32'(bus.vga_gnt), 32'd0);
        chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
        chk("rst_vga_rdata", bus.vga_rdata, 32'h0);
        chk("rst_overflow", 32'(bus.kb_overflow), 32'd0);
        tick();
        rst = 1'b1;

        // Single key code written to the mailbox
        bus.kb_valid = 1; bus.kb_code = 8'h1C; kb_q.push_back(32'h0000_011C);
        @(negedge clk);
        chk("t1_idle_we", 32'(bus.mem_we), 32'd0);
        tick();
        bus.kb_valid = 0;
        @(negedge clk);
        chk("t1_kb_we", 32'(bus.mem_we), 32'd1);
        chk("t1_kb_wd", bus.mem_wd, 32'h0000_011C);
        tick();
        @(negedge clk);
        chk("t1_after_we", 32'(bus.mem_we), 32'd0);
        tick();

        // Table of single-cycle ownership vectors (FIFO empty)
        for (int i = 0; i < 7; i++) begin
            bus.cpu_req = tbl[i].cpu_req; bus.cpu_we = tbl[i].cpu_we;
            bus.cpu_addr = tbl[i].cpu_addr; bus.cpu_wd = tbl[i].cpu_wd;
            bus.vga_req = tbl[i].vga_req; bus.vga_addr = tbl[i].vga_addr;
            @(negedge clk);
            chk($sformatf("tbl%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_wd", i), bus.mem_wd, tbl[i].e_wd);
            chk($sformatf("tbl%0d_gnt", i), 32'(bus.vga_gnt), 32'(tbl[i].e_gnt));
            if (tbl[i].rd_chk) chk($sformatf("tbl%0d_cpu_rd", i), bus.cpu_rd, tbl[i].e_rd);
            tick();
        end
        @(negedge clk);
        chk("hold_rvalid", 32'(bus.vga_rvalid), 32'd0);
        chk("hold_rdata", bus.vga_rdata, 32'hDEAD_BEEF);
        tick();

        // CPU priority over pending key and VGA, then KB before VGA
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'hDEAD_BEEF;
        bus.vga_req = 1; bus.vga_addr = 32'h100;
        bus.kb_valid = 1; bus.kb_code = 8'h2A; kb_q.push_back(32'h0000_012A);
        @(negedge clk);
        chk("t2a_addr", bus.mem_addr, 32'h40);
        chk("t2a_gnt", 32'(bus.vga_gnt), 32'd0);
        tick();
        bus.kb_valid = 0;
        @(negedge clk);
        chk("t2b_addr", bus.mem_addr, 32'h40);
        chk("t2b_gnt", 32'(bus.vga_gnt), 32'd0);
        tick();
        bus.cpu_req = 0; bus.cpu_we = 0;
        @(negedge clk);
        chk("t2c_kb_we", 32'(bus.mem_we), 32'd1);
        chk("t2c_kb_wd", bus.mem_wd, 32'h0000_012A);
        chk("t2c_gnt", 32'(bus.vga_gnt), 32'd0);
        tick();
        @(negedge clk);
        chk("t2d_gnt", 32'(bus.vga_gnt), 32'd1);
        chk("t2d_addr", bus.mem_addr, 32'h100);
        tick();
        bus.vga_req = 0;
        @(negedge clk);
        chk("t3_rvalid", 32'(bus.vga_rvalid), 32'd1);
        chk("t3_rdata", bus.vga_rdata, 32'h1234_5678);
        tick();

        // Full FIFO with a push coinciding with a pop: push accepted
        bus.cpu_req = 1;
        for (int i = 0; i < 4; i++) begin
            bus.kb_valid = 1; bus.kb_code = 8'h31 + 8'(i);
            kb_q.push_back(32'h0000_0131 + 32'(i));
            tick();
        end
        bus.cpu_req = 0; bus.kb_code = 8'h35; kb_q.push_back(32'h0000_0135);
        @(negedge clk);
        chk("t5_kb_we", 32'(bus.mem_we), 32'd1);
        tick();
        bus.kb_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_drained", 32'(kb_q.size()), 32'd0);
        chk("t5_no_overflow", 32'(bus.kb_overflow), 32'd0);

        // Overflow: five codes while the CPU holds the port
        bus.cpu_req = 1;
        for (int i = 1; i <= 5; i++) begin
            bus.kb_valid = 1; bus.kb_code = 8'(i);
            if (i <= 4) kb_q.push_back(32'h0000_0100 + 32'(i));
            if (i == 5) begin
                @(negedge clk);
                chk("t4_pre_overflow", 32'(bus.kb_overflow), 32'd0);
            end
            tick();
        end
        bus.kb_valid = 0;
        @(negedge clk);
        chk("t4_overflow", 32'(bus.kb_overflow), 32'd1);
        tick();
        bus.cpu_req = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_drained", 32'(kb_q.size()), 32'd0);
        chk("t4_overflow_sticky", 32'(bus.kb_overflow), 32'd1);

        // Reset mid-drain with codes buffered and a VGA grant in flight
        bus.cpu_req = 1;
        for (int i = 0; i < 3; i++) begin
            bus.kb_valid = 1; bus.kb_code = 8'h41 + 8'(i);
            tick();
        end
        bus.kb_valid = 0; bus.cpu_req = 0;
        bus.vga_req = 1; bus.vga_addr = 32'h100;
        @(negedge clk);
        chk("t6_vga_gnt", 32'(bus.vga_gnt), 32'd1);
        #1;
        rst = 1'b0; bus.vga_req = 0;
        #1;
        vga_q.delete();
        chk("t6_rst_overflow", 32'(bus.kb_overflow), 32'd0);
        chk("t6_rst_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("t6_rst_rvalid", 32'(bus.vga_rvalid), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t6_post_we%0d", i), 32'(bus.mem_we), 32'd0);
            tick();
        end
        chk("t6_rvalid", 32'(bus.vga_rvalid), 32'd0);
        chk("end_kb_q", 32'(kb_q.size()), 32'd0);
        chk("end_vga_q", 32'(vga_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
